masked_sel_pipe_reg: RTL and testbench

- Parametrised successor to the single-bit select/enable share flip-flop, for masked-cipher datapaths.
- Holds a SHARES-share, WIDTH-bit masked value in a DEPTH-stage register pipeline.
- Stage 0 input is selected per cycle between a load source (d0) and a round-feedback source (d1).
- Adds per-stage valid tracking, fill count and flush; sits between share-wise S-box/linear layers and the round state register.

---
 rtl/masked_sel_pipe_reg.sv | 115 +++++++++++
 tb/tb_masked_sel_pipe_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/masked_sel_pipe_reg.sv
// masked_sel_pipe_reg
//   Share-preserving select/enable register pipeline for masked-cipher
//   datapaths. Holds a SHARES-share, WIDTH-bit masked value in a DEPTH-stage
//   pipeline. Stage 0 captures either the load source (d0) or the
//   round-feedback source (d1). Every stage carries a valid bit. A fill
//   count and a full flag are derived from the valid bits.
//
//   Shares are never combined: the input mux works per bit and per share,
//   and every register is a plain DFF.
//
// Parameters
//   WIDTH   bits per share
//   SHARES  number of Boolean shares
//   DEPTH   pipeline stages (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears data and valids)
//   en       advance all stages together; hold when low
//   sel      stage-0 source select: 0 -> d0, 1 -> d1
//   in_vld   qualifies the stage-0 capture
//   flush    synchronous clear of all valid bits (data unaffected)
//   d0, d1   load / feedback sources, share s in [s*WIDTH +: WIDTH]
//   q        last-stage data
//   q_vld    last-stage valid
//   fill     number of valid stages
//   full     fill == DEPTH
//   zeroize  (only with MASKED_SEL_PIPE_ZEROIZE_EN) synchronous wipe of
//            all data and valid bits; overrides flush and en
//
// Optional build macro: MASKED_SEL_PIPE_ZEROIZE_EN

module masked_sel_pipe_reg #(
  parameter int WIDTH  = 4,
  parameter int SHARES = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       sel,
  input  logic                       in_vld,
  input  logic                       flush,
`ifdef MASKED_SEL_PIPE_ZEROIZE_EN
  input  logic                       zeroize,
`endif
  input  logic [SHARES*WIDTH-1:0]    d0,
  input  logic [SHARES*WIDTH-1:0]    d1,
  output logic [SHARES*WIDTH-1:0]    q,
  output logic                       q_vld,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full
);

  localparam int DW = SHARES * WIDTH;
  localparam int FW = $clog2(DEPTH + 1);

  logic [DW-1:0]    stage [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DW-1:0]    stage0_nxt;
  logic [FW-1:0]    fill_cnt;

  // Per-share, per-bit source mux; no share ever sees another's bits.
  for (genvar s = 0; s < SHARES; s++) begin : g_share_mux
    assign stage0_nxt[s*WIDTH +: WIDTH] = sel ? d1[s*WIDTH +: WIDTH]
                                              : d0[s*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
      vld <= '0;
    end
`ifdef MASKED_SEL_PIPE_ZEROIZE_EN
    else if (zeroize) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
      vld <= '0;
    end
`endif
    else begin
      // Data follows en only; flush acts on the valid bits alone.
      if (en) begin
        stage[0] <= stage0_nxt;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
      if (flush) begin
        vld <= '0;
      end else if (en) begin
        vld[0] <= in_vld;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
        end
      end
    end
  end

  always_comb begin
    fill_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fill_cnt = fill_cnt + FW'(vld[i]);
    end
  end

  assign q     = stage[DEPTH-1];
  assign q_vld = vld[DEPTH-1];
  assign fill  = fill_cnt;
  assign full  = (fill_cnt == FW'(DEPTH));

endmodule

// File: tb/tb_masked_sel_pipe_reg.sv
// tb_masked_sel_pipe_reg
//   Self-checking bench for masked_sel_pipe_reg (WIDTH=4, SHARES=3, DEPTH=2).
//   A directed vector table is followed by hand-written multi-cycle
//   sequences: reset, hold, mid-stream reset and, when the build defines
//   MASKED_SEL_PIPE_ZEROIZE_EN, zeroize. A randomized phase then compares
//   the DUT against a queue-based pipeline model.

module tb_masked_sel_pipe_reg;

  localparam int W  = 4;
  localparam int S  = 3;
  localparam int D  = 2;
  localparam int DW = W * S;
  localparam int FW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, sel, in_vld, flush;
  logic          zeroize;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] q;
  logic          q_vld;
  logic [FW-1:0] fill;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  masked_sel_pipe_reg #(.WIDTH(W), .SHARES(S), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .sel    (sel),
    .in_vld (in_vld),
    .flush  (flush),
`ifdef MASKED_SEL_PIPE_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .d0     (d0),
    .d1     (d1),
    .q      (q),
    .q_vld  (q_vld),
    .fill   (fill),
    .full   (full)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [DW-1:0] eq,
                           input logic eqv, input int efill);
    check({tag, " q"},     32'(q),     32'(eq));
    check({tag, " q_vld"}, 32'(q_vld), 32'(eqv));
    check({tag, " fill"},  32'(fill),  32'(efill));
    check({tag, " full"},  32'(full),  32'(efill == D));
  endtask

  task automatic drive(input logic e, input logic s, input logic v,
                       input logic f, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    en = e; sel = s; in_vld = v; flush = f; d0 = a; d1 = b;
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    zeroize = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Reference model: the pipeline is a queue of (data, valid) entries,
  // newest at the front, last stage at index D-1.
  logic [DW-1:0] m_d [$];
  bit            m_v [$];

  task automatic model_reset;
    m_d = {};
    m_v = {};
    for (int i = 0; i < D; i++) begin
      m_d.push_back('0);
      m_v.push_back(1'b0);
    end
  endtask

  task automatic model_step(input logic e, input logic s, input logic v,
                            input logic f, input logic [DW-1:0] a,
                            input logic [DW-1:0] b);
    if (e) begin
      m_d.push_front(s ? b : a);
      m_v.push_front(v);
      void'(m_d.pop_back());
      void'(m_v.pop_back());
    end
    if (f) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
    end
  endtask

  function automatic int model_fill();
    int c = 0;
    foreach (m_v[i]) c += int'(m_v[i]);
    return c;
  endfunction

  typedef struct {
    logic          en, sel, in_vld, flush;
    logic [DW-1:0] d0, d1;
    logic [DW-1:0] eq;
    logic          eqv;
    int            efill;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Directed table, applied from the reset state; each row is one edge.
    vecs[0]  = '{1, 0, 1, 0, 12'h123, 12'h000, 12'h000, 0, 1}; // load 123
    vecs[1]  = '{1, 0, 0, 0, 12'h000, 12'h000, 12'h123, 1, 1}; // 123 at q
    vecs[2]  = '{1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0}; // drained
    vecs[3]  = '{1, 1, 1, 0, 12'h555, 12'hABC, 12'h000, 0, 1}; // feedback
    vecs[4]  = '{1, 1, 1, 0, 12'h555, 12'hABC, 12'hABC, 1, 2}; // full
    vecs[5]  = '{1, 0, 1, 1, 12'h777, 12'h000, 12'hABC, 0, 0}; // flush+en
    vecs[6]  = '{1, 0, 0, 0, 12'h000, 12'h000, 12'h777, 0, 0}; // data kept
    vecs[7]  = '{0, 1, 1, 0, 12'h000, 12'hFFF, 12'h777, 0, 0}; // hold
    vecs[8]  = '{0, 1, 1, 1, 12'h000, 12'hFFF, 12'h777, 0, 0}; // flush, en=0
    vecs[9]  = '{1, 1, 1, 0, 12'h000, 12'h246, 12'h000, 0, 1};
    vecs[10] = '{0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 0, 0}; // flush holds data
    vecs[11] = '{1, 0, 0, 0, 12'h000, 12'h000, 12'h246, 0, 0};

    do_reset();
    check_all("reset", 12'h000, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].in_vld, vecs[i].flush,
            vecs[i].d0, vecs[i].d1);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eqv,
                vecs[i].efill);
    end

    // Hold: capture 3C7, stall five cycles with random inputs.
    do_reset();
    drive(1, 0, 1, 0, 12'h3C7, 12'h000);
    tick();
    check_all("hold cap", 12'h000, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 0, 12'($urandom), 12'($urandom));
      tick();
      check_all($sformatf("hold%0d", i), 12'h000, 1'b0, 1);
    end
    drive(1, 0, 0, 0, 12'h000, 12'h000);
    tick();
    check_all("hold done", 12'h3C7, 1'b1, 1);

    // Asynchronous reset mid-stream with fill=2.
    drive(1, 1, 1, 0, 12'h000, 12'h9D2);
    tick();
    tick();
    check_all("pre-rst", 12'h9D2, 1'b1, 2);
    #2 rst_n = 1'b0;
    #1 check_all("async rst", 12'h000, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MASKED_SEL_PIPE_ZEROIZE_EN
    // Zeroize with fill=2 wipes data and valids despite en=1.
    drive(1, 0, 1, 0, 12'h5A5, 12'h000);
    tick();
    tick();
    check_all("pre-zero", 12'h5A5, 1'b1, 2);
    zeroize = 1'b1;
    tick();
    check_all("zeroize", 12'h000, 1'b0, 0);
    zeroize = 1'b0;
    drive(1, 0, 0, 0, 12'h000, 12'h000);
    tick();
    check_all("post-zero", 12'h000, 1'b0, 0);
`endif

    // Randomized phase against the queue model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic          e, s, v, f;
      logic [DW-1:0] a, b;
      e = ($urandom_range(9) < 7);
      s = 1'($urandom);
      v = 1'($urandom);
      f = ($urandom_range(9) == 0);
      a = 12'($urandom);
      b = 12'($urandom);
      drive(e, s, v, f, a, b);
      model_step(e, s, v, f, a, b);
      tick();
      check_all($sformatf("rnd%0d", i), m_d[D-1], m_v[D-1], model_fill());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
